// File: rtl/br_ram_init_arbiter.sv
// Owns the RAM ports: starts the initializer, forwards its write stream, then opens user traffic.
// Watches the initializer protocol (in-order addresses, exactly Depth writes) and flags violations stickily.
module br_ram_init_arbiter #(
    parameter int Depth = 2,
    parameter int Width = 1,
    parameter bit InitOnReset = 1'b1,
    localparam int AddressWidth = $clog2(Depth)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_req,
    output logic                    init_done,
    output logic                    init_err,
    output logic                    ini_start,
    input  logic                    ini_busy,
    input  logic                    ini_wr_valid,
    input  logic [AddressWidth-1:0] ini_wr_addr,
    input  logic [Width-1:0]        ini_wr_data,
    input  logic                    usr_wr_valid,
    output logic                    usr_wr_ready,
    input  logic [AddressWidth-1:0] usr_wr_addr,
    input  logic [Width-1:0]        usr_wr_data,
    input  logic                    usr_rd_valid,
    output logic                    usr_rd_ready,
    input  logic [AddressWidth-1:0] usr_rd_addr,
    output logic                    ram_wr_valid,
    output logic [AddressWidth-1:0] ram_wr_addr,
    output logic [Width-1:0]        ram_wr_data,
    output logic                    ram_rd_valid,
    output logic [AddressWidth-1:0] ram_rd_addr
);

    localparam int CountWidth = AddressWidth + 1;
    localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        INIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CountWidth-1:0] exp_addr;
    logic [CountWidth-1:0] exp_addr_inc;
    logic [CountWidth-1:0] exp_addr_final;
    logic                  seen_busy;
    logic                  busy_fall;
    logic                  addr_err;
    logic                  count_err;
    logic                  stray_err;
    logic                  usr_wr_fire;

    always_comb begin
        state_d   = state_q;
        ini_start = 1'b0;
        init_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (InitOnReset || init_req) begin
                    state_d = START;
                end
            end
            START: begin
                ini_start = 1'b1;
                state_d   = INIT;
            end
            INIT: begin
                if (busy_fall) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                init_done = 1'b1;
                if (init_req) begin
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_fall    = seen_busy && !ini_busy;
    assign usr_wr_ready = (state_q == DONE);
    assign usr_rd_ready = (state_q == DONE);
    assign usr_wr_fire  = usr_wr_valid && usr_wr_ready;
    assign ram_rd_valid = usr_rd_valid && (state_q == DONE);
    assign ram_rd_addr  = usr_rd_addr;

    // Saturate rather than wrap so an overlong write burst can never look correct again.
    assign exp_addr_inc   = (exp_addr == '1) ? exp_addr : exp_addr + CountWidth'(1);
    assign exp_addr_final = ini_wr_valid ? exp_addr_inc : exp_addr;

    assign addr_err  = (state_q == INIT) && ini_wr_valid && ({1'b0, ini_wr_addr} != exp_addr);
    assign count_err = (state_q == INIT) && busy_fall && (exp_addr_final != DepthCount);
    assign stray_err = ini_wr_valid && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_addr     <= '0;
            seen_busy    <= 1'b0;
            init_err     <= 1'b0;
            ram_wr_valid <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
        end else begin
            state_q <= state_d;

            if (addr_err || count_err || stray_err) begin
                init_err <= 1'b1;
            end

            if (state_q == START) begin
                exp_addr  <= '0;
                seen_busy <= 1'b0;
            end else if (state_q == INIT) begin
                if (ini_busy) begin
                    seen_busy <= 1'b1;
                end
                exp_addr <= exp_addr_final;
            end

            if (state_q == INIT) begin
                ram_wr_valid <= ini_wr_valid;
                ram_wr_addr  <= ini_wr_addr;
                ram_wr_data  <= ini_wr_data;
            end else if (usr_wr_fire) begin
                ram_wr_valid <= 1'b1;
                ram_wr_addr  <= usr_wr_addr;
                ram_wr_data  <= usr_wr_data;
            end else begin
                ram_wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_br_ram_init_arbiter.sv
// Scoreboard bench for br_ram_init_arbiter: a behavioural initializer and user-traffic driver push
// expected RAM writes; a negedge monitor pops and compares every RAM write the DUT issues.
module tb_br_ram_init_arbiter;

    localparam int Depth = 4;
    localparam int Width = 8;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_req = 1'b0;
    logic          init_done, init_err, ini_start;
    logic          ini_busy = 1'b0;
    logic          ini_wr_valid = 1'b0;
    logic [AW-1:0] ini_wr_addr = '0;
    logic [Width-1:0] ini_wr_data = '0;
    logic          usr_wr_valid = 1'b0;
    logic          usr_wr_ready;
    logic [AW-1:0] usr_wr_addr = '0;
    logic [Width-1:0] usr_wr_data = '0;
    logic          usr_rd_valid = 1'b0;
    logic          usr_rd_ready;
    logic [AW-1:0] usr_rd_addr = '0;
    logic          ram_wr_valid;
    logic [AW-1:0] ram_wr_addr;
    logic [Width-1:0] ram_wr_data;
    logic          ram_rd_valid;
    logic [AW-1:0] ram_rd_addr;

    always #5 clk = ~clk;

    br_ram_init_arbiter #(.Depth(Depth), .Width(Width), .InitOnReset(1'b1)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done), .init_err(init_err),
        .ini_start(ini_start), .ini_busy(ini_busy), .ini_wr_valid(ini_wr_valid),
        .ini_wr_addr(ini_wr_addr), .ini_wr_data(ini_wr_data),
        .usr_wr_valid(usr_wr_valid), .usr_wr_ready(usr_wr_ready), .usr_wr_addr(usr_wr_addr),
        .usr_wr_data(usr_wr_data), .usr_rd_valid(usr_rd_valid), .usr_rd_ready(usr_rd_ready),
        .usr_rd_addr(usr_rd_addr), .ram_wr_valid(ram_wr_valid), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_valid(ram_rd_valid), .ram_rd_addr(ram_rd_addr)
    );

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [Width-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0;
    int  fails = 0;
    int  start_count = 0;
    bit  err_model = 1'b0;
    logic [Width-1:0] val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (ini_start === 1'b1) start_count++;
        if (ram_wr_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL ram_wr unexpected write actual addr=%0h data=%0h required none", ram_wr_addr, ram_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (ram_wr_addr !== mon_e.addr || ram_wr_data !== mon_e.data) begin
                    fails++;
                    $display("FAIL ram_wr actual addr=%0h data=%0h required addr=%0h data=%0h",
                             ram_wr_addr, ram_wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ini_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL ini_start_timeout actual=0 required=1");
        end
    endtask

    // Behavioural initializer: nwr writes of v, optionally skipping address 1, optional init_req noise.
    task automatic run_init(input logic [Width-1:0] v, input int nwr, input bit skip, input bit req_mid);
        bit ok;
        int s0;
        logic [AW-1:0] a;
        s0 = start_count;
        wait_start(ok);
        if (!ok) return;
        step();
        check("ini_start_single", ini_start, 0);
        ini_busy = 1'b1;
        for (int i = 0; i < nwr; i++) begin
            a = (skip && i >= 1) ? AW'(i + 1) : AW'(i);
            ini_wr_valid = 1'b1;
            ini_wr_addr  = a;
            ini_wr_data  = v;
            init_req     = req_mid;
            usr_rd_valid = 1'b1;
            usr_rd_addr  = AW'($urandom);
            exp_q.push_back('{addr: a, data: v});
            #1;
            check("rd_blocked_init", ram_rd_valid, 0);
            check("wr_ready_init", usr_wr_ready, 0);
            step();
            if (skip && i == 1) check("err_addr_skip", init_err, 1);
        end
        ini_wr_valid = 1'b0;
        ini_wr_data  = Width'($urandom);
        usr_rd_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        init_req = 1'b0;
        check("done_before_fall", init_done, 0);
        ini_busy = 1'b0;
        step();
        err_model = err_model | skip | (nwr != Depth);
        check("init_done", init_done, 1);
        check("usr_ready_done", usr_wr_ready, 1);
        check("start_count", start_count - s0, 1);
        check("init_err", init_err, err_model);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            usr_wr_valid = 1'($urandom);
            usr_wr_addr  = AW'($urandom);
            usr_wr_data  = Width'($urandom);
            usr_rd_valid = 1'($urandom);
            usr_rd_addr  = AW'($urandom);
            #1;
            check("rd_ready", usr_rd_ready, 1);
            check("rd_valid", ram_rd_valid, usr_rd_valid);
            check("rd_addr", ram_rd_addr, usr_rd_addr);
            if (usr_wr_valid) exp_q.push_back('{addr: usr_wr_addr, data: usr_wr_data});
            step();
        end
        usr_wr_valid = 1'b0;
        usr_rd_valid = 1'b0;
    endtask

    task automatic dme_request();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("done_drop", init_done, 0);
    endtask

    initial begin
        bit ok;
        repeat (3) step();
        check("rst_init_done", init_done, 0);
        check("rst_init_err", init_err, 0);
        check("rst_ini_start", ini_start, 0);
        check("rst_ram_wr_valid", ram_wr_valid, 0);
        check("rst_ram_wr_addr", ram_wr_addr, 0);
        check("rst_ram_wr_data", ram_wr_data, 0);
        rst = 1'b0;
        step();
        check("start_cycle1", ini_start, 1);

        // user write held across init, accepted only once DONE
        usr_wr_valid = 1'b1;
        usr_wr_addr  = 2'd2;
        usr_wr_data  = 8'hA5;
        run_init(8'h3C, 4, 1'b0, 1'b0);
        exp_q.push_back('{addr: 2'd2, data: 8'hA5});
        step();
        usr_wr_valid = 1'b0;
        random_traffic(30);

        // reinit with init_req noise during INIT
        dme_request();
        val = Width'($urandom);
        run_init(val, 4, 1'b0, 1'b1);
        random_traffic(20);

        // init_req and user write in the same DONE cycle
        init_req     = 1'b1;
        usr_wr_valid = 1'b1;
        usr_wr_addr  = 2'd1;
        usr_wr_data  = 8'h77;
        exp_q.push_back('{addr: 2'd1, data: 8'h77});
        step();
        init_req     = 1'b0;
        usr_wr_valid = 1'b0;
        check("done_drop_req_wr", init_done, 0);
        val = Width'($urandom);
        run_init(val, 4, 1'b0, 1'b0);

        // out-of-order addresses, error stays sticky
        dme_request();
        val = Width'($urandom);
        run_init(val, 2, 1'b1, 1'b0);
        random_traffic(5);
        check("err_sticky", init_err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        err_model = 1'b0;
        check("err_cleared_rst", init_err, 0);

        // short burst: only three writes
        val = Width'($urandom);
        run_init(val, 3, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        err_model = 1'b0;
        val = Width'($urandom);
        run_init(val, 4, 1'b0, 1'b0);

        // reset arriving with the second init write
        dme_request();
        wait_start(ok);
        step();
        ini_busy     = 1'b1;
        ini_wr_valid = 1'b1;
        ini_wr_addr  = 2'd0;
        ini_wr_data  = 8'h11;
        exp_q.push_back('{addr: 2'd0, data: 8'h11});
        step();
        ini_wr_addr = 2'd1;
        rst = 1'b1;
        step();
        check("rstmid_ram_wr_valid", ram_wr_valid, 0);
        check("rstmid_ram_wr_addr", ram_wr_addr, 0);
        check("rstmid_ram_wr_data", ram_wr_data, 0);
        check("rstmid_init_done", init_done, 0);
        check("rstmid_ini_start", ini_start, 0);
        rst = 1'b0;
        ini_wr_valid = 1'b0;
        ini_busy = 1'b0;
        val = Width'($urandom);
        run_init(val, 4, 1'b0, 1'b0);

        // initializer write while DONE is a protocol error and never reaches the RAM
        ini_wr_valid = 1'b1;
        ini_wr_addr  = 2'd3;
        step();
        ini_wr_valid = 1'b0;
        check("err_stray_write", init_err, 1);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
